// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, prefetch queue entry,
// instruction alignment and zero-instruction constants.
// The datapath width comes from `WORD_LENGTH (defaults to 32).
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package instr_fetch_unit_pkg;
  localparam int WL = `WORD_LENGTH;

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALT} ifu_state_t;

  typedef struct packed {
    logic [WL-1:0] instr;
    logic [WL-1:0] pstate0;
    logic [WL-1:0] pstate1;
    logic          fault;
  } ifu_entry_t;

  localparam logic [WL-1:0] INSTR_ALIGN_MASK = ~WL'(3);
  localparam logic [WL-1:0] NOP_INSTR        = '0;
  localparam logic [WL-1:0] ZERO_INSTR       = '0;

  // Force an offset onto a word boundary.
  function automatic logic [WL-1:0] align_pc(input logic [WL-1:0] pc);
    return pc & INSTR_ALIGN_MASK;
  endfunction
endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Prefetch queue (ifu_queue): synchronous FIFO with occupancy count,
// flush, and same-cycle push/pop. DEPTH must be a power of two.
module instr_fetch_unit_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  ifu_entry_t    din,
  output ifu_entry_t    dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  ifu_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is accepted only when a pop frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers and count; flush discards everything, including this cycle's push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Entry storage, not reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch offset, issues one I-MEM
// request at a time, buffers responses and hands them to decode.
// Optional IFU_PERF_CNT_EN adds a saturating decode-bubble counter port.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                     WORD_LENGTH  = `WORD_LENGTH,
  parameter int                     QUEUE_DEPTH  = 2,
  parameter logic [WORD_LENGTH-1:0] RESET_OFFSET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [WORD_LENGTH-1:0] redirectPstate0,
  input  logic [WORD_LENGTH-1:0] redirectPstate1,
  output logic                   imemReq,
  output logic [WORD_LENGTH-1:0] imemAdr,
  output logic [WORD_LENGTH-1:0] imemSeg,
  input  logic                   imemAck,
  input  logic [WORD_LENGTH-1:0] imemData,
  input  logic                   imemErr,
  output logic                   outValid,
  input  logic                   deReady,
  output logic [WORD_LENGTH-1:0] outInstr,
  output logic [WORD_LENGTH-1:0] outPstate0,
  output logic [WORD_LENGTH-1:0] outPstate1,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]            bubbleCnt,
`endif
  output logic                   outFault
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  ifu_state_t             state_q, state_d;
  logic [WORD_LENGTH-1:0] pc_q, pc_d, ps0_q, ps0_d;
  logic                   req_d;
  logic [WORD_LENGTH-1:0] adr_d, seg_d;
  logic                   push, full, q_empty;
  logic [CW-1:0]          q_count;
  ifu_entry_t             enq, head, out_e;

  // Enqueued entry carries the address/segment that were actually requested.
  assign enq.instr   = imemErr ? ZERO_INSTR : imemData;
  assign enq.pstate0 = imemSeg;
  assign enq.pstate1 = imemAdr;
  assign enq.fault   = imemErr;
  assign full        = (q_count == CW'(QUEUE_DEPTH));

  instr_fetch_unit_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (outValid && deReady),
    .flush (redirect),
    .din   (enq),
    .dout  (head),
    .count (q_count),
    .empty (q_empty)
  );

  // Empty queue presents all-zero outputs.
  assign out_e      = q_empty ? '0 : head;
  assign outValid   = !q_empty;
  assign outInstr   = out_e.instr;
  assign outPstate0 = out_e.pstate0;
  assign outPstate1 = out_e.pstate1;
  assign outFault   = out_e.fault;

  // Next-state, next request and enqueue decisions; redirect overrides all.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ps0_d   = ps0_q;
    req_d   = imemReq;
    adr_d   = imemAdr;
    seg_d   = imemSeg;
    push    = 1'b0;
    unique case (state_q)
      FETCH: if (!full) begin
        req_d   = 1'b1;
        adr_d   = pc_q;
        seg_d   = ps0_q;
        state_d = WAIT;
      end
      WAIT: if (imemAck) begin
        req_d   = 1'b0;
        push    = !redirect;
        pc_d    = pc_q + WORD_LENGTH'(4);
        state_d = imemErr ? HALT : FETCH;
      end
      DRAIN: if (imemAck) begin
        req_d   = 1'b0;
        state_d = FETCH;
      end
      default: ;
    endcase
    if (redirect) begin
      ps0_d = redirectPstate0;
      pc_d  = align_pc(redirectPstate1);
      if ((state_q == WAIT || state_q == DRAIN) && !imemAck) begin
        // Request still in flight: keep it on the bus and discard its reply.
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
        req_d   = 1'b0;
        adr_d   = imemAdr;
        seg_d   = imemSeg;
      end
    end
  end

  // State, fetch target and registered I-MEM request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_OFFSET;
      ps0_q   <= '0;
      imemReq <= 1'b0;
      imemAdr <= '0;
      imemSeg <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ps0_q   <= ps0_d;
      imemReq <= req_d;
      imemAdr <= adr_d;
      imemSeg <= seg_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Count cycles where decode could accept but nothing is available.
  always_ff @(posedge clk) begin
    if (rst)                                           bubbleCnt <= '0;
    else if (deReady && !outValid && bubbleCnt != '1)  bubbleCnt <= bubbleCnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (QUEUE_DEPTH=2, RESET_OFFSET=0x100).
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, redirect, imemAck, imemErr, deReady;
  logic [31:0] redirectPstate0, redirectPstate1, imemData;
  logic        imemReq, outValid, outFault;
  logic [31:0] imemAdr, imemSeg, outInstr, outPstate0, outPstate1;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] bubbleCnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int nreq;

  instr_fetch_unit #(.WORD_LENGTH(32), .QUEUE_DEPTH(2), .RESET_OFFSET(32'h100)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirectPstate0 (redirectPstate0),
    .redirectPstate1 (redirectPstate1),
    .imemReq         (imemReq),
    .imemAdr         (imemAdr),
    .imemSeg         (imemSeg),
    .imemAck         (imemAck),
    .imemData        (imemData),
    .imemErr         (imemErr),
    .outValid        (outValid),
    .deReady         (deReady),
    .outInstr        (outInstr),
    .outPstate0      (outPstate0),
    .outPstate1      (outPstate1),
`ifdef IFU_PERF_CNT_EN
    .bubbleCnt       (bubbleCnt),
`endif
    .outFault        (outFault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [31:0] d, input logic e);
    imemAck  = 1'b1;
    imemData = d;
    imemErr  = e;
    cyc();
    imemAck  = 1'b0;
    imemErr  = 1'b0;
    imemData = '0;
  endtask

  task automatic redir(input logic [31:0] p0, input logic [31:0] p1);
    redirect        = 1'b1;
    redirectPstate0 = p0;
    redirectPstate1 = p1;
    cyc();
    redirect        = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(imemReq), 32'd0);
    chk({tag, "_adr"}, imemAdr, 32'h0);
    chk({tag, "_seg"}, imemSeg, 32'h0);
    chk({tag, "_vld"}, 32'(outValid), 32'd0);
    chk({tag, "_ins"}, outInstr, 32'h0);
    chk({tag, "_ps0"}, outPstate0, 32'h0);
    chk({tag, "_ps1"}, outPstate1, 32'h0);
    chk({tag, "_flt"}, 32'(outFault), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; imemAck = 1'b0; imemErr = 1'b0; deReady = 1'b1;
    redirectPstate0 = '0; redirectPstate1 = '0; imemData = '0;
    cyc(); cyc();
    rst = 1'b0;
    // reset state
    chk_zero("rst");
`ifdef IFU_PERF_CNT_EN
    chk("rst_bubble", bubbleCnt, 32'd0);
`endif

    // basic fetch from RESET_OFFSET
    cyc();
    chk("f1_req", 32'(imemReq), 32'd1);
    chk("f1_adr", imemAdr, 32'h100);
    ack(32'hA0000001, 1'b0);
    chk("f1_vld", 32'(outValid), 32'd1);
    chk("f1_ins", outInstr, 32'hA0000001);
    chk("f1_ps1", outPstate1, 32'h100);
    chk("f1_req0", 32'(imemReq), 32'd0);
    cyc();
    chk("f2_req", 32'(imemReq), 32'd1);
    chk("f2_adr", imemAdr, 32'h104);
    chk("f2_vld0", 32'(outValid), 32'd0);
    ack(32'hA0000002, 1'b0);
    chk("f2_ins", outInstr, 32'hA0000002);
    chk("f2_ps1", outPstate1, 32'h104);

    // backpressure: queue fills with exactly QUEUE_DEPTH requests
    cyc();
    deReady = 1'b0;
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      if (imemReq) begin
        nreq++;
        imemAck  = 1'b1;
        imemData = 32'hB0000000 + 32'(nreq);
      end else begin
        imemAck  = 1'b0;
      end
      cyc();
    end
    imemAck = 1'b0;
    chk("bp_nreq", 32'(nreq), 32'd2);
    chk("bp_req0", 32'(imemReq), 32'd0);
    chk("bp_hold", outInstr, 32'hB0000001);
    chk("bp_ps1a", outPstate1, 32'h108);
    deReady = 1'b1;
    cyc();
    chk("bp_ins2", outInstr, 32'hB0000002);
    chk("bp_ps1b", outPstate1, 32'h10C);
    cyc();
    chk("bp_empty", 32'(outValid), 32'd0);
    chk("bp_adr", imemAdr, 32'h110);

    // redirect while WAIT -> DRAIN, response discarded
    redir(32'h7, 32'h2003);
    chk("dr_req", 32'(imemReq), 32'd1);
    chk("dr_adr", imemAdr, 32'h110);
    cyc(); cyc();
    ack(32'hDEADBEEF, 1'b0);
    chk("dr_vld0", 32'(outValid), 32'd0);
    chk("dr_req0", 32'(imemReq), 32'd0);
    cyc();
    chk("dr_nadr", imemAdr, 32'h2000);
    chk("dr_nseg", imemSeg, 32'h7);

    // fault entry and HALT
    ack(32'hC0000001, 1'b0);
    chk("c_ins", outInstr, 32'hC0000001);
    chk("c_ps0", outPstate0, 32'h7);
    redir(32'h9, 32'h40);
    chk("er_flush", 32'(outValid), 32'd0);
    cyc();
    chk("er_adr", imemAdr, 32'h40);
    ack(32'h12345678, 1'b1);
    chk("er_flt", 32'(outFault), 32'd1);
    chk("er_ins", outInstr, 32'h0);
    chk("er_ps1", outPstate1, 32'h40);
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      if (imemReq) nreq++;
      cyc();
    end
    chk("halt_nreq", 32'(nreq), 32'd0);
    chk("halt_pop", 32'(outValid), 32'd0);
    redir(32'h9, 32'h80);
    cyc();
    chk("res_req", 32'(imemReq), 32'd1);
    chk("res_adr", imemAdr, 32'h80);
    ack(32'hD0000001, 1'b0);

    // offset wrap with pstate0 unaffected
    redir(32'h5, 32'hFFFFFFFC);
    cyc();
    chk("wr_adr1", imemAdr, 32'hFFFFFFFC);
    chk("wr_seg1", imemSeg, 32'h5);
    ack(32'hE0000001, 1'b0);
    chk("wr_ps1", outPstate1, 32'hFFFFFFFC);
    chk("wr_ps0", outPstate0, 32'h5);
    cyc();
    chk("wr_req2", 32'(imemReq), 32'd1);
    chk("wr_adr2", imemAdr, 32'h0);
    chk("wr_seg2", imemSeg, 32'h5);

    // reset mid-WAIT with a late ack
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    imemAck  = 1'b1;
    imemData = 32'h55;
    chk_zero("rst2");
    cyc();
    imemAck = 1'b0;
    chk("rst2_vld", 32'(outValid), 32'd0);
    chk("rst2_adr", imemAdr, 32'h100);
    ack(32'hF0000001, 1'b0);
    chk("rst2_ins", outInstr, 32'hF0000001);
    chk("rst2_ps1", outPstate1, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Pipeline front end that sits directly upstream of the fetch/decode stage.
- Owns the instruction offset, issues word requests to the I-MEM interface over a request/acknowledge handshake, and buffers returned words in a small queue.
- Presents one instruction per cycle, with its pstate pair, to the decoder under a valid/ready handshake.
- Handles pipeline redirects (branches, traps) and I-MEM errors.

Parameters:
- WORD_LENGTH, 32, datapath width; must equal `WORD_LENGTH.
- QUEUE_DEPTH, 2, prefetch queue entries; power of two, 2..8.
- RESET_OFFSET, 32'h0, instruction offset loaded at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- redirect  in  1  load a new fetch target and flush.
- redirectPstate0  in  WORD_LENGTH  new status/segment word.
- redirectPstate1  in  WORD_LENGTH  new instruction offset.
- imemReq  out  1  request valid.
- imemAdr  out  WORD_LENGTH  word-aligned offset requested.
- imemSeg  out  WORD_LENGTH  pstate0 sent with the request.
- imemAck  in  1  response valid; completes the outstanding request.
- imemData  in  WORD_LENGTH  instruction word.
- imemErr  in  1  fetch fault; qualified by imemAck.
- outValid  out  1  instruction available to decode.
- deReady  in  1  decode accepts this cycle.
- outInstr  out  WORD_LENGTH  instruction word.
- outPstate0  out  WORD_LENGTH  pstate0 of the instruction.
- outPstate1  out  WORD_LENGTH  offset of the instruction.
- outFault  out  1  entry carries an I-MEM error; outInstr is then 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - fetchPc=RESET_OFFSET, pstate0=0, queue empty, state=FETCH.
  - imemReq=0, imemAdr=0, imemSeg=0.
  - outValid=0, outInstr=0, outPstate0=0, outPstate1=0, outFault=0.
  - Reset mid-request: the outstanding request is abandoned. A late imemAck in a later cycle is ignored while state!=WAIT.
- States:
  - FETCH: if (queue count + 0 outstanding) < QUEUE_DEPTH, assert imemReq with imemAdr=fetchPc and go to WAIT.
  - WAIT:
    - imemReq, imemAdr and imemSeg are held stable until imemAck.
    - On imemAck: enqueue {imemData, pstate0, imemAdr, imemErr}; fetchPc += 4; go to FETCH, or HALT if imemErr.
  - DRAIN:
    - Entered when redirect occurs in WAIT.
    - imemReq stays asserted with the old address until imemAck.
    - The response is discarded; then go to FETCH with the new target.
  - HALT: no requests are issued. Only redirect or rst exits.
- One outstanding request max. The earliest imemAck is the cycle after imemReq rises.
- Latency:
  - Redirect at edge N: imemReq rises in cycle N+1 with the new address, or after DRAIN completes.
  - imemAck at edge M: outValid=1 from M+1 if the queue was empty. There is no combinational data bypass.
- Output handshake:
  - The head entry drives out*. It pops when outValid && deReady.
  - Enqueue and pop in the same cycle: count unchanged.
  - Outputs are held stable while outValid && !deReady.
- Redirect:
  - Flushes the queue, so outValid=0 the next cycle.
  - Loads pstate0=redirectPstate0 and fetchPc={redirectPstate1[31:2],2'b00}.
  - Has priority over a same-cycle pop and enqueue; the acked word in that cycle is dropped.
  - Redirect during DRAIN overwrites the target and stays in DRAIN.
- Offset arithmetic: 32-bit. 0xFFFFFFFC+4 wraps to 0x00000000 with no carry into pstate0.
- Full: no request is issued while count==QUEUE_DEPTH. Empty: outValid=0.
- Fault entry: outFault=1, outInstr=0. It pops like a normal entry.

Optional Feature:
- IFU_PERF_CNT_EN
- Defined:
  - Adds output port bubbleCnt (32 bits).
  - Increments each cycle deReady && !outValid, saturating at 0xFFFFFFFF.
  - Cleared by rst.
- Undefined: no port and no counter logic; behaviour otherwise identical.

Decomposition:
- Shared package, reused by the decode stage:
  - ifu_state_t enum {FETCH, WAIT, DRAIN, HALT}.
  - Queue entry struct {instr, pstate0, pstate1, fault}.
  - INSTR_ALIGN_MASK and NOP/zero-instruction constants.
- Sub-module: ifu_queue, a parameterised synchronous FIFO with count, push/pop/flush and simultaneous push/pop support.

Test Plan:
- Reset with RESET_OFFSET=0x100, deReady=1, I-MEM acks in the next cycle, data 0xA0000001,0xA0000002 -> imemAdr 0x100 then 0x104; outInstr in order with outPstate1 0x100,0x104.
- deReady=0 for 6 cycles, QUEUE_DEPTH=2 -> exactly 2 requests issued and imemReq=0 once full; on release, entries drain in order with no loss or duplicates.
- Redirect to offset 0x2003 while WAIT, ack 3 cycles later -> acked word discarded, outValid=0, next imemAdr=0x2000.
- imemAck with imemErr=1 at offset 0x40 -> entry with outFault=1, outInstr=0; no further imemReq until redirect to 0x80 -> fetch resumes at 0x80.
- Redirect to 0xFFFFFFFC with pstate0 0x5 -> requests 0xFFFFFFFC then 0x00000000, imemSeg=0x5 both times.
- rst asserted mid-WAIT followed by a late imemAck -> the ack is ignored; first new request is at RESET_OFFSET; all outputs are 0 in the cycle after reset.
